uart_tx_fifo: RTL

// Next-generation UART transmitter with a parametrised FIFO in front of the serialiser.
// - Generalises the fixed 8-bit TX: data width, parity mode (none/even/odd) and stop bits are parameters.
// - Adds an internal buffer, plus busy and level status, for back-to-back frames with no host gaps.
// - Sits between a host write port and the board TX pin; baud timing comes from an NCO.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_nco.sv | 16 +
 rtl/uart_tx_fifo.sv | 89 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and baud increment helper
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;
  function automatic int nco_inc(input real clk_freq, input real baud, input int width);
    return $rtoi(baud * (2.0 ** width) / clk_freq + 0.5);
  endfunction
endpackage

// File: rtl/uart_baud_nco.sv
// uart_baud_nco: phase accumulator whose carry out is the baud tick
module uart_baud_nco #(
  parameter int NCO_WIDTH = 16,
  parameter logic [NCO_WIDTH-1:0] INC = 75
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  logic [NCO_WIDTH-1:0] acc;
  logic [NCO_WIDTH:0] sum;
  assign sum = {1'b0, acc} + {1'b0, INC};
  assign tick = sum[NCO_WIDTH];
  always_ff @(posedge clk) acc <= (rst || clr) ? '0 : sum[NCO_WIDTH-1:0];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable frame format
module uart_tx_fifo import uart_pkg::*; #(
  parameter real     CLK_FREQ    = 100e6,
  parameter real     BAUD_RATE   = 115200.0,
  parameter int      NCO_WIDTH   = 16,
  parameter int      DATA_BITS   = 8,
  parameter parity_e PARITY_MODE = PAR_EVEN,
  parameter int      STOP_BITS   = 1,
  parameter int      FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dvld,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          ready,
  output logic                          overflow,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [NCO_WIDTH-1:0] INC = NCO_WIDTH'(nco_inc(CLK_FREQ, BAUD_RATE, NCO_WIDTH));
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] sh, head;
  logic [AW:0] wp, rp;
  logic [3:0] cnt;
  logic par, rst_d, tick, empty, full, push, pop, last_stop, line;
  tx_state_e state;
  assign level = wp - rp;
  assign empty = wp == rp;
  assign full = level == (AW+1)'(FIFO_DEPTH);
  assign ready = !full && !rst_d;
  assign push = dvld && ready;
  assign last_stop = state == S_STOP && tick && cnt == 4'(STOP_BITS - 1);
  assign pop = !empty && (state == S_IDLE || last_stop);
  assign head = mem[rp[AW-1:0]];
  assign busy = state != S_IDLE || !empty;
  assign line = state == S_START ? 1'b0 : state == S_DATA ? sh[0] : state == S_PARITY ? par : 1'b1;
  // clearing only on launch from idle keeps back-to-back frames phase-continuous
  uart_baud_nco #(.NCO_WIDTH(NCO_WIDTH), .INC(INC)) u_nco (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_IDLE && !empty),
    .tick (tick)
  );
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      state <= S_IDLE;
      cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      rst_d <= 1'b1;
      overflow <= 1'b0;
      uart_tx <= 1'b1;
    end else begin
      rst_d <= 1'b0;
      overflow <= dvld && !ready;
      uart_tx <= line;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        sh <= head;
        par <= ^head ^ (PARITY_MODE == PAR_ODD);
        state <= S_START;
      end else if (tick) begin
        if (state == S_START) begin
          state <= S_DATA;
          cnt <= '0;
        end else if (state == S_DATA) begin
          sh <= sh >> 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(DATA_BITS - 1)) begin
            state <= PARITY_MODE == PAR_NONE ? S_STOP : S_PARITY;
            cnt <= '0;
          end
        end else if (state == S_PARITY) begin
          state <= S_STOP;
          cnt <= '0;
        end else if (state == S_STOP) begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(STOP_BITS - 1)) state <= S_IDLE;
        end
      end
    end
  end
endmodule
